// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: protocol byte values, pause-sequence length,
// frame FSM state encoding and a classifier for keyboard housekeeping bytes.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  // Bytes that follow E1 in the pause make sequence (14 77 E1 F0 14 F0 77).
  localparam int PAUSE_TAIL = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_st_e;

  // Self-test, ack, resend, echo and error bytes carry no key information.
  function automatic logic is_housekeeping(input logic [7:0] b);
    return (b == PS2_BAT)    || (b == PS2_ACK)  || (b == PS2_RESEND) ||
           (b == PS2_ECHO)   || (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 input conditioning: 2-FF synchronisers on clock and data, a
// glitch filter on the clock and a one-cycle pulse on each filtered
// falling edge.
// Ports:
//   clk_sys, reset      system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous pins
//   data_sync           synchronised data, valid to capture on sample_evt
//   sample_evt          one-cycle pulse, cycle after filtered clock fell
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic sample_evt
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_meta;
  logic [1:0]    data_meta;
  logic          clk_filt;
  logic [CW-1:0] run_cnt;

  assign data_sync = data_meta[1];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_meta   <= 2'b11;
      data_meta  <= 2'b11;
      clk_filt   <= 1'b1;
      run_cnt    <= '0;
      sample_evt <= 1'b0;
    end else begin
      clk_meta   <= {clk_meta[0], ps2_clk};
      data_meta  <= {data_meta[0], ps2_data};
      sample_evt <= 1'b0;
      // run_cnt counts consecutive samples disagreeing with clk_filt; any
      // agreeing sample restarts the run, so short glitches are swallowed.
      if (clk_meta[1] == clk_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        clk_filt   <= ~clk_filt;
        run_cnt    <= '0;
        sample_evt <= clk_filt;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: frames the serial stream, checks start/parity/
// stop, tracks E0/F0 prefixes, swallows the E1 pause sequence and
// housekeeping bytes, and emits make/break events for the matrix decoder.
// Ports:
//   clk_sys, reset      system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw PS/2 pins
//   key_strobe          one-cycle pulse per make/break event
//   key_pressed         1 = make, 0 = break (held until next strobe)
//   key_extended        event was E0-prefixed (held)
//   key_code            scan code without prefixes (held)
//   frame_err           one-cycle pulse on start/parity/stop error or timeout
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT);

  logic          data_sync;
  logic          sample_evt;

  frame_st_e     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          byte_vld;
  logic [7:0]    rx_byte;

  logic          ext_flag;
  logic          brk_flag;
  logic [2:0]    skip_cnt;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_sync  (data_sync),
    .sample_evt (sample_evt)
  );

  // Frame FSM with timeout. A sample event always takes priority over the
  // timeout so a bit arriving on the last allowed cycle is still accepted.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_vld  <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (sample_evt) begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (!data_sync) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shreg   <= {data_sync, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= data_sync;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            if (data_sync && (^{shreg, par_bit})) begin
              byte_vld <= 1'b1;
              rx_byte  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          state     <= ST_IDLE;
          to_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  // Byte decode, one cycle behind byte_vld. frame_err and byte_vld are
  // mutually exclusive, so an error simply drops any pending prefix.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      key_strobe   <= 1'b0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= 8'h00;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      skip_cnt     <= '0;
    end else begin
      key_strobe <= 1'b0;
      if (frame_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_vld) begin
        if (skip_cnt != '0) begin
          skip_cnt <= skip_cnt - 1'b1;
        end else if (rx_byte == PS2_PAUSE) begin
          skip_cnt <= 3'(PAUSE_TAIL);
        end else if (rx_byte == PS2_EXT) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == PS2_BREAK) begin
          brk_flag <= 1'b1;
        end else if (!is_housekeeping(rx_byte)) begin
          key_code     <= rx_byte;
          key_pressed  <= ~brk_flag;
          key_extended <= ext_flag;
          key_strobe   <= 1'b1;
          ext_flag     <= 1'b0;
          brk_flag     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 1000;
  localparam int HALF       = 40;   // 500 ns clock -> 40 us bit period
  localparam int GAP        = 100;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_strobe, key_pressed, key_extended, frame_err;
  logic [7:0] key_code;

  ps2_scancode_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_strobe   (key_strobe),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_code     (key_code),
    .frame_err    (frame_err)
  );

  always #250 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
    int         lat;
  } ev_t;

  ev_t ev_q[$];
  ev_t exp_q[$];
  ev_t mon_e;
  ev_t exp_e;
  int  cyc = 0, last_fall = 0, n_err = 0, n_both = 0, exp_err = 0;
  int  total = 0, bad = 0;

  // Reference model state (pure protocol rules on a byte stream).
  logic       m_ext = 0, m_brk = 0;
  int         m_skip = 0;
  logic [7:0] m_last_code = 8'h00;
  logic       m_last_pressed = 0, m_last_ext = 0;

  always @(negedge clk_sys) begin
    cyc++;
    if (dut.sample_evt) last_fall = cyc;
    if (key_strobe) begin
      mon_e.code = key_code; mon_e.pressed = key_pressed;
      mon_e.ext = key_extended; mon_e.lat = cyc - last_fall;
      ev_q.push_back(mon_e);
    end
    if (frame_err) n_err++;
    if (frame_err && key_strobe) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic void model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE ||
             b == 8'h00 || b == 8'hFF) begin
    end else begin
      exp_e.code = b; exp_e.pressed = !m_brk; exp_e.ext = m_ext; exp_e.lat = 2;
      exp_q.push_back(exp_e);
      m_last_code = b; m_last_pressed = !m_brk; m_last_ext = m_ext;
      m_ext = 0; m_brk = 0;
    end
  endfunction

  function automatic void model_err();
    m_ext = 0; m_brk = 0; exp_err++;
  endfunction

  // Device-side frame: data changes while clock is high, clock falls mid-bit.
  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                            input bit glitch = 0, input int nbits = 11);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch && i == 4) begin
        wait_cyc(20); ps2_clk = 0; wait_cyc(3); ps2_clk = 1; wait_cyc(HALF - 23);
      end else wait_cyc(HALF);
      ps2_clk = 0;
      if (glitch && i == 6) begin
        wait_cyc(15); ps2_clk = 1; wait_cyc(3); ps2_clk = 0; wait_cyc(HALF - 18);
      end else wait_cyc(HALF);
      ps2_clk = 1;
    end
    ps2_data = 1;
    wait_cyc(GAP);
  endtask

  task automatic good(input logic [7:0] b, input bit glitch = 0);
    send_frame(b, 0, glitch);
    model_byte(b);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, ev_q.size(), exp_q.size());
    while (ev_q.size() > 0 && exp_q.size() > 0) begin
      mon_e = ev_q.pop_front();
      exp_e = exp_q.pop_front();
      chk({tag, "_code"},    mon_e.code,    exp_e.code);
      chk({tag, "_pressed"}, mon_e.pressed, exp_e.pressed);
      chk({tag, "_ext"},     mon_e.ext,     exp_e.ext);
      chk({tag, "_latency"}, mon_e.lat,     exp_e.lat);
    end
    ev_q.delete();
    exp_q.delete();
    chk({tag, "_errs"}, n_err, exp_err);
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] code,
                               input logic pressed, input logic ext);
    chk({tag, "_strobe"},  key_strobe,   1'b0);
    chk({tag, "_ferr"},    frame_err,    1'b0);
    chk({tag, "_code"},    key_code,     code);
    chk({tag, "_pressed"}, key_pressed,  pressed);
    chk({tag, "_ext"},     key_extended, ext);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    bit bp;

    // Reset state
    wait_cyc(5);
    check_outputs("rst_in", 8'h00, 0, 0);
    reset = 0;
    wait_cyc(20);
    check_outputs("rst_out", 8'h00, 0, 0);

    // Plain make
    good(8'h1C);
    check_events("make_1c");
    check_outputs("hold_1c", 8'h1C, 1, 0);

    // Break
    good(8'hF0); good(8'h1C);
    check_events("break_1c");

    // Extended break, then bare make
    good(8'hE0); good(8'hF0); good(8'h75); good(8'h75);
    check_events("ext_75");

    // Parity error drops the pending E0
    good(8'hE0);
    send_frame(8'h16, 1); model_err();
    good(8'h16);
    check_events("parity_16");

    // Pause sequence swallowed, then 29; housekeeping bytes ignored
    good(8'hE1); good(8'h14); good(8'h77); good(8'hE1);
    good(8'hF0); good(8'h14); good(8'hF0); good(8'h77);
    good(8'hAA); good(8'hFA);
    good(8'h29);
    check_events("pause_29");

    // Glitches on the clock mid-frame
    good(8'h3A, 1);
    check_events("glitch_3a");

    // Timeout after a partial frame, pending prefix dropped
    good(8'hE0);
    send_frame(8'h33, 0, 0, 5);
    wait_cyc(TIMEOUT + 200);
    model_err();
    chk("timeout_state_idle", dut.state, 2'd0);
    good(8'h5A);
    check_events("timeout_5a");

    // Reset mid-frame: no strobe, no error, outputs cleared
    good(8'hE0);
    send_frame(8'h44, 0, 0, 5);
    @(negedge clk_sys); reset = 1;
    wait_cyc(3);
    check_outputs("midrst_in", 8'h00, 0, 0);
    reset = 0;
    m_ext = 0; m_brk = 0; m_skip = 0;
    m_last_code = 8'h00; m_last_pressed = 0; m_last_ext = 0;
    wait_cyc(TIMEOUT + 200);
    check_outputs("midrst_out", 8'h00, 0, 0);
    good(8'h44);
    check_events("midrst_44");

    // Randomised byte stream with occasional parity errors
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      send_frame(b, bp);
      if (bp) model_err(); else model_byte(b);
    end
    check_events("random");
    check_outputs("random_hold", m_last_code, m_last_pressed, m_last_ext);
    chk("strobe_err_overlap", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(64'd60_000_000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
